// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - hazard control handshake bundle
// Purpose: groups the ID/EX/MEM hazard inputs and the pipeline control
// outputs of hazard_control_unit.
// master: pipeline side (drives the stage fields, receives the controls)
// slave : hazard_control_unit (receives the stage fields, drives the controls)
interface hazard_control_unit_if #(
  parameter int COUNT_WIDTH = 32
);
  logic [4:0]             Rs_Id;
  logic [4:0]             Rt_Id;
  logic                   UsesRt_Id;
  logic                   Branch_Id;
  logic                   BranchTaken_Id;
  logic                   MulDiv_Id;
  logic                   HiLoRead_Id;
  logic [4:0]             Rd_Ex;
  logic                   RegWrite_Ex;
  logic                   MemRead_Ex;
  logic [4:0]             Rd_Mem;
  logic                   MemRead_Mem;
  logic                   PCWrite;
  logic                   IFIDWrite;
  logic                   IFIDFlush;
  logic                   IDEXBubble;
  logic                   MulDivStart;
  logic                   MulDivBusy;
  logic [COUNT_WIDTH-1:0] StallCount;

  modport master (
    output Rs_Id, Rt_Id, UsesRt_Id, Branch_Id, BranchTaken_Id, MulDiv_Id,
           HiLoRead_Id, Rd_Ex, RegWrite_Ex, MemRead_Ex, Rd_Mem, MemRead_Mem,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulDivStart,
           MulDivBusy, StallCount
  );

  modport slave (
    input  Rs_Id, Rt_Id, UsesRt_Id, Branch_Id, BranchTaken_Id, MulDiv_Id,
           HiLoRead_Id, Rd_Ex, RegWrite_Ex, MemRead_Ex, Rd_Mem, MemRead_Mem,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulDivStart,
           MulDivBusy, StallCount
  );
endinterface

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline hazard sequencer for the 5-stage core
// Purpose: detects load-use, ID-branch operand and mult/div hazards, drives
// PC/IF-ID/ID-EX enables and flushes, and schedules the mult/div unit.
// Ports:
//   Clk - clock
//   Rst - synchronous active-high reset
//   hz  - hazard_control_unit_if.slave: ID/EX/MEM fields in, pipeline
//         controls, MulDivStart/MulDivBusy and StallCount out
module hazard_control_unit #(
  parameter int MULDIV_LATENCY = 32,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  hazard_control_unit_if.slave  hz
);

  localparam logic [7:0] MD_LAT = 8'(MULDIV_LATENCY);

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  md_state_t              md_state, md_state_nxt;
  logic [7:0]             md_cnt, md_cnt_nxt;
  logic [COUNT_WIDTH-1:0] stall_count;

  logic match_ex, match_mem;
  logic load_use, branch_haz, md_haz, stall, md_start;

  // Register 0 is hardwired to zero, so writes to it never create a hazard.
  assign match_ex  = (hz.Rd_Ex != 5'd0) &&
                     ((hz.Rd_Ex == hz.Rs_Id) || (hz.UsesRt_Id && (hz.Rd_Ex == hz.Rt_Id)));
  assign match_mem = (hz.Rd_Mem != 5'd0) &&
                     ((hz.Rd_Mem == hz.Rs_Id) || (hz.UsesRt_Id && (hz.Rd_Mem == hz.Rt_Id)));

  assign load_use   = hz.MemRead_Ex && match_ex;
  // The branch compares in ID, so any in-flight producer in EX, or a load
  // still in MEM, is too late to forward.
  assign branch_haz = hz.Branch_Id &&
                      ((hz.RegWrite_Ex && match_ex) || (hz.MemRead_Mem && match_mem));
  assign md_haz     = (md_state == MD_BUSY) && (hz.MulDiv_Id || hz.HiLoRead_Id);
  assign stall      = load_use || branch_haz || md_haz;

  // md_haz blocks a second start while busy, so only MD_IDLE sees a start.
  assign md_start   = hz.MulDiv_Id && !stall && !Rst;

  always_comb begin
    hz.PCWrite     = !stall;
    hz.IFIDWrite   = !stall;
    hz.IDEXBubble  = stall;
    // A taken flag seen while stalled is stale; the branch re-resolves later.
    hz.IFIDFlush   = hz.BranchTaken_Id && !stall;
    hz.MulDivStart = md_start;
    if (Rst) begin
      hz.PCWrite    = 1'b0;
      hz.IFIDWrite  = 1'b0;
      hz.IFIDFlush  = 1'b1;
      hz.IDEXBubble = 1'b1;
    end
  end

  assign hz.MulDivBusy = (md_state == MD_BUSY);
  assign hz.StallCount = stall_count;

  // Busy spans exactly MULDIV_LATENCY cycles: the last busy cycle holds
  // md_cnt==1 and the FSM drops back to idle on the following edge.
  always_comb begin
    md_state_nxt = md_state;
    md_cnt_nxt   = md_cnt;
    case (md_state)
      MD_IDLE: begin
        if (md_start) begin
          md_state_nxt = MD_BUSY;
          md_cnt_nxt   = MD_LAT;
        end
      end
      MD_BUSY: begin
        if (md_cnt <= 8'd1) begin
          md_state_nxt = MD_IDLE;
          md_cnt_nxt   = 8'd0;
        end else begin
          md_cnt_nxt   = md_cnt - 8'd1;
        end
      end
      default: begin
        md_state_nxt = MD_IDLE;
        md_cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      md_state    <= MD_IDLE;
      md_cnt      <= 8'd0;
      stall_count <= '0;
    end else begin
      md_state <= md_state_nxt;
      md_cnt   <= md_cnt_nxt;
      if (stall && (stall_count != {COUNT_WIDTH{1'b1}})) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - directed bench for hazard_control_unit
module tb_hazard_control_unit;

  localparam int LAT = 4;
  localparam int CW  = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  always #5 Clk = ~Clk;

  hazard_control_unit_if #(.COUNT_WIDTH(CW)) hif ();

  hazard_control_unit #(.MULDIV_LATENCY(LAT), .COUNT_WIDTH(CW)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .hz  (hif.slave)
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesrt;
    logic       br;
    logic       taken;
    logic       hilo;
    logic [4:0] rdex;
    logic       regwr;
    logic       memrd;
    logic [4:0] rdmem;
    logic       memrdmem;
    logic       exp_stall;
    logic       exp_flush;
  } vec_t;

  vec_t tbl [12];

  int checks = 0;
  int passed = 0;
  int sc     = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clear_in();
    hif.Rs_Id = 5'd0; hif.Rt_Id = 5'd0; hif.UsesRt_Id = 1'b0;
    hif.Branch_Id = 1'b0; hif.BranchTaken_Id = 1'b0; hif.MulDiv_Id = 1'b0;
    hif.HiLoRead_Id = 1'b0; hif.Rd_Ex = 5'd0; hif.RegWrite_Ex = 1'b0;
    hif.MemRead_Ex = 1'b0; hif.Rd_Mem = 5'd0; hif.MemRead_Mem = 1'b0;
  endtask

  task automatic sc_step(input logic st);
    if (st) sc = (sc == (1 << CW) - 1) ? sc : sc + 1;
  endtask

  task automatic chk_ctl(input string tag, input logic st, input logic fl, input logic start);
    chk({tag, "_pcwrite"},   int'(hif.PCWrite),     int'(!st));
    chk({tag, "_ifidwrite"}, int'(hif.IFIDWrite),   int'(!st));
    chk({tag, "_bubble"},    int'(hif.IDEXBubble),  int'(st));
    chk({tag, "_flush"},     int'(hif.IFIDFlush),   int'(fl));
    chk({tag, "_start"},     int'(hif.MulDivStart), int'(start));
  endtask

  initial begin
    //            rs     rt     ur    br    tk    hl    rdex   rw    mr    rdm    mrm   st    fl
    tbl[0]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0};
    tbl[1]  = '{5'd8,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd8,  1'b1, 1'b1, 5'd0,  1'b0, 1'b1, 1'b0};
    tbl[2]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0};
    tbl[3]  = '{5'd1,  5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 5'd9,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0};
    tbl[4]  = '{5'd1,  5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 5'd9,  1'b1, 1'b1, 5'd0,  1'b0, 1'b1, 1'b0};
    tbl[5]  = '{5'd5,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0};
    tbl[6]  = '{5'd5,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 5'd5,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1};
    tbl[7]  = '{5'd3,  5'd7,  1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd7,  1'b1, 1'b1, 1'b0};
    tbl[8]  = '{5'd3,  5'd7,  1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd7,  1'b1, 1'b0, 1'b1};
    tbl[9]  = '{5'd5,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0};
    tbl[10] = '{5'd8,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 5'd8,  1'b1, 1'b1, 5'd0,  1'b0, 1'b1, 1'b0};
    tbl[11] = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0};

    // Reset: outputs forced, start suppressed even with a mult in ID.
    clear_in();
    hif.MulDiv_Id = 1'b1;
    @(negedge Clk); #1;
    chk_ctl("rst", 1'b1, 1'b1, 1'b0);
    @(negedge Clk);
    Rst = 1'b0;
    clear_in();
    #1;
    chk("rst_busy",  int'(hif.MulDivBusy), 0);
    chk("rst_count", int'(hif.StallCount), 0);
    sc = 0;

    // Single-cycle combinational vectors.
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      hif.Rs_Id = tbl[i].rs; hif.Rt_Id = tbl[i].rt; hif.UsesRt_Id = tbl[i].usesrt;
      hif.Branch_Id = tbl[i].br; hif.BranchTaken_Id = tbl[i].taken;
      hif.MulDiv_Id = 1'b0; hif.HiLoRead_Id = tbl[i].hilo;
      hif.Rd_Ex = tbl[i].rdex; hif.RegWrite_Ex = tbl[i].regwr; hif.MemRead_Ex = tbl[i].memrd;
      hif.Rd_Mem = tbl[i].rdmem; hif.MemRead_Mem = tbl[i].memrdmem;
      #1;
      chk_ctl($sformatf("v%0d", i), tbl[i].exp_stall, tbl[i].exp_flush, 1'b0);
      chk($sformatf("v%0d_count", i), int'(hif.StallCount), sc);
      sc_step(tbl[i].exp_stall);
    end

    // Mult then dependent mfhi held from T+1.
    @(negedge Clk); clear_in(); hif.MulDiv_Id = 1'b1; #1;
    chk_ctl("mdA_T", 1'b0, 1'b0, 1'b1);
    chk("mdA_T_busy", int'(hif.MulDivBusy), 0);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge Clk); clear_in(); hif.HiLoRead_Id = 1'b1; #1;
      chk_ctl($sformatf("mdA_T%0d", k), 1'b1, 1'b0, 1'b0);
      chk($sformatf("mdA_T%0d_busy", k), int'(hif.MulDivBusy), 1);
      sc_step(1'b1);
    end
    @(negedge Clk); clear_in(); hif.HiLoRead_Id = 1'b1; #1;
    chk_ctl("mdA_rel", 1'b0, 1'b0, 1'b0);
    chk("mdA_rel_busy", int'(hif.MulDivBusy), 0);
    chk("mdA_count", int'(hif.StallCount), 9);

    // Back-to-back mult: second start held until T+5.
    @(negedge Clk); clear_in(); hif.MulDiv_Id = 1'b1; #1;
    chk_ctl("mdB_T", 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge Clk); clear_in(); hif.MulDiv_Id = 1'b1; #1;
      chk_ctl($sformatf("mdB_T%0d", k), 1'b1, 1'b0, 1'b0);
      sc_step(1'b1);
    end
    @(negedge Clk); clear_in(); hif.MulDiv_Id = 1'b1; #1;
    chk_ctl("mdB_T5", 1'b0, 1'b0, 1'b1);
    chk("mdB_T5_busy", int'(hif.MulDivBusy), 0);
    @(negedge Clk); clear_in(); #1;
    chk("mdB_T6_busy",  int'(hif.MulDivBusy), 1);
    chk("mdB_T6_start", int'(hif.MulDivStart), 0);

    // Reset at the second busy cycle of the new operation.
    @(negedge Clk); Rst = 1'b1; clear_in(); #1;
    chk_ctl("mdrst", 1'b1, 1'b1, 1'b0);
    chk("mdrst_busy_before", int'(hif.MulDivBusy), 1);
    @(negedge Clk); Rst = 1'b0; clear_in(); #1;
    chk("mdrst_busy",  int'(hif.MulDivBusy), 0);
    chk("mdrst_count", int'(hif.StallCount), 0);
    sc = 0;
    @(negedge Clk); clear_in(); #1;
    chk("mdrst_busy_stays", int'(hif.MulDivBusy), 0);

    // Saturation of the stall counter.
    for (int k = 0; k < 18; k++) begin
      @(negedge Clk); clear_in();
      hif.MemRead_Ex = 1'b1; hif.Rd_Ex = 5'd12; hif.Rs_Id = 5'd12; #1;
      chk($sformatf("sat%0d_count", k), int'(hif.StallCount), sc);
      sc_step(1'b1);
    end
    @(negedge Clk); clear_in(); #1;
    chk("sat_final", int'(hif.StallCount), (1 << CW) - 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline hazard sequencer for the 5-stage MIPS core; sits beside the forwarding logic and drives the PC/IF-ID/ID-EX write-enables and flushes.
- Detects load-use and ID-stage branch-operand hazards that forwarding cannot cover, and inserts bubbles for them.
- Squashes the wrong-path fetch on a taken branch.
- Schedules the shared multi-cycle mult/div unit: issues the start pulse, tracks busy time, and stalls dependent HI/LO reads and back-to-back mult/div.

Parameters:
- MULDIV_LATENCY, 32, cycles the mult/div unit is busy after a start; legal range 1 to 255.
- COUNT_WIDTH, 32, width of the stall-cycle performance counter.

Ports:
- Clk  input  1  clock
- Rst  input  1  synchronous active-high reset
- Rs_Id  input  5  Rs field of the instruction in ID
- Rt_Id  input  5  Rt field of the instruction in ID
- UsesRt_Id  input  1  ID instruction reads Rt as a source
- Branch_Id  input  1  ID instruction is a branch compared in ID
- BranchTaken_Id  input  1  ID branch comparison resolved taken
- MulDiv_Id  input  1  ID instruction is mult/multu/div/divu
- HiLoRead_Id  input  1  ID instruction is mfhi/mflo
- Rd_Ex  input  5  destination register selected in EX
- RegWrite_Ex  input  1  EX instruction writes the register file
- MemRead_Ex  input  1  EX instruction is a load
- Rd_Mem  input  5  destination register in MEM
- MemRead_Mem  input  1  MEM instruction is a load
- PCWrite  output  1  PC update enable
- IFIDWrite  output  1  IF/ID register write enable
- IFIDFlush  output  1  zero the IF/ID register
- IDEXBubble  output  1  load NOP control into ID/EX
- MulDivStart  output  1  one-cycle start pulse to the mult/div unit
- MulDivBusy  output  1  mult/div unit occupied
- StallCount  output  COUNT_WIDTH  saturating count of stall cycles

Behaviour:
- Clock and reset: single clock Clk; Rst is synchronous and active-high, sampled on the rising edge.
- Reset state: the registered state is MdState=MD_IDLE, MdCnt=0, StallCount=0, so MulDivBusy=0.
- Outputs while Rst=1:
  - PCWrite=0, IFIDWrite=0
  - IFIDFlush=1, IDEXBubble=1
  - MulDivStart=0
- Register numbers:
  - Match(r) = (r != 0) && (r == Rs_Id || (UsesRt_Id && r == Rt_Id)).
  - Register 0 never causes a hazard.
- LoadUse = MemRead_Ex && Match(Rd_Ex).
- BranchHaz = Branch_Id && ((RegWrite_Ex && Match(Rd_Ex)) || (MemRead_Mem && Match(Rd_Mem))).
- MdHaz = MulDivBusy && (MulDiv_Id || HiLoRead_Id).
- Stall = LoadUse || BranchHaz || MdHaz.
- Output equations (combinational, same cycle; no added latency):
  - PCWrite = !Stall
  - IFIDWrite = !Stall
  - IDEXBubble = Stall
  - IFIDFlush = BranchTaken_Id && !Stall. A taken flag is ignored while stalled; the branch re-resolves once its operands are ready.
  - MulDivStart = MulDiv_Id && !Stall. MdHaz guarantees MulDivStart=0 while busy.
- Mult/div FSM states: MD_IDLE, MD_BUSY.
  - MD_IDLE: on MulDivStart, load MdCnt=MULDIV_LATENCY and go to MD_BUSY.
  - MD_BUSY: MdCnt decrements each cycle; return to MD_IDLE when MdCnt reaches 0.
  - MulDivBusy = (MdState == MD_BUSY).
  - Timing: start in cycle T gives MulDivBusy=1 for cycles T+1 through T+MULDIV_LATENCY inclusive. A dependent mfhi is released at T+MULDIV_LATENCY+1.
  - MULDIV_LATENCY=1 gives exactly one busy cycle.
- Simultaneous events:
  - Load-use and taken branch together: stall wins, no flush.
  - Busy expiring in the same cycle that mfhi sits in ID: still stalled that cycle; released the next cycle.
- StallCount increments by 1 each non-reset cycle with Stall=1 and saturates at all-ones (no wrap).
- Reset mid-operation: Rst during MD_BUSY returns to MD_IDLE with MdCnt=0 next edge; no start pulse is issued.

Test Plan:
- Load-use: MemRead_Ex=1, Rd_Ex=8, Rs_Id=8 → PCWrite=0, IFIDWrite=0, IDEXBubble=1 for that cycle; StallCount goes 0→1. Same stimulus with Rd_Ex=0 → no stall.
- Rt gating: Rd_Ex=9, Rt_Id=9, MemRead_Ex=1, UsesRt_Id=0 → no stall; with UsesRt_Id=1 → stall.
- Branch hazard: Branch_Id=1, RegWrite_Ex=1, Rd_Ex=5, Rs_Id=5, BranchTaken_Id=1 → IFIDFlush=0, IDEXBubble=1. Next cycle, with the hazard gone and still taken → IFIDFlush=1, PCWrite=1.
- Mult/div with MULDIV_LATENCY=4: MulDiv_Id at T → MulDivStart=1 at T; MulDivBusy=1 for T+1..T+4. Holding HiLoRead_Id=1 from T+1 → stall for T+1..T+4 and released at T+5; StallCount=4.
- Back-to-back mult: second MulDiv_Id at T+1 → no MulDivStart until T+5, when exactly one pulse occurs.
- Reset: Rst asserted at T+2 of a busy period → MulDivBusy=0 and StallCount=0 after the edge. With StallCount preloaded to all-ones, a further stall cycle leaves it at all-ones.
